calc_accum: RTL and testbench

Parametrised add/subtract accumulator for the switch-and-button calculator boards. It debounces two raw push buttons (enter, mode) internally and holds a running WIDTH-bit result. Each enter press either loads the switch operand or adds/subtracts it from the accumulator, with carry/borrow and signed-overflow flags. It replaces the fixed 8-bit, single-shot add/sub top with a reusable core that the board top wraps with pin mapping and LEDs.

---
 rtl/calc_accum_if.sv | 38 +++
 rtl/calc_accum.sv | 158 +++++++++++++++
 tb/tb_calc_accum.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_accum_if.sv
// rtl/calc_accum_if.sv - operand/button/result bundle for the calc_accum core
//
// Purpose: groups the calculator data and button lines so that the board top
// and the core share one connection.
// Ports (signals):
//   i_operand   WIDTH  switch operand (quasi-static)
//   i_btn_enter 1      raw enter button, active-high, bouncy
//   i_btn_mode  1      raw mode button, active-high, bouncy
//   o_result    WIDTH  accumulator value
//   o_carry     1      add: carry-out; sub: 1 = no borrow
//   o_overflow  1      signed overflow of the last operation
//   o_mode_sub  1      0 = add, 1 = subtract
//   o_loaded    1      accumulator holds a loaded operand
//   o_valid     1      one-cycle pulse when result/flags update
// Modports: master drives the inputs (board/bench), slave is the core.
interface calc_accum_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_operand;
  logic             i_btn_enter;
  logic             i_btn_mode;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
  logic             o_overflow;
  logic             o_mode_sub;
  logic             o_loaded;
  logic             o_valid;

  modport master (
    output i_operand, i_btn_enter, i_btn_mode,
    input  o_result, o_carry, o_overflow, o_mode_sub, o_loaded, o_valid
  );

  modport slave (
    input  i_operand, i_btn_enter, i_btn_mode,
    output o_result, o_carry, o_overflow, o_mode_sub, o_loaded, o_valid
  );
endinterface

// File: rtl/calc_accum.sv
// rtl/calc_accum.sv - debounced add/subtract accumulator core
//
// Purpose: debounces the enter and mode buttons, then loads or adds/subtracts
// the switch operand into a WIDTH-bit accumulator with carry and signed
// overflow flags. All outputs are registered.
// Ports:
//   CLK  in   system clock, rising edge
//   RST  in   asynchronous active-high reset
//   bus  slave calc_accum_if (operand, buttons in; result, flags, valid out)
// Parameters:
//   WIDTH          operand/accumulator width (>= 2)
//   DEBOUNCE_LIMIT stable cycles needed to accept a button change (>= 1)
module calc_accum #(
  parameter int WIDTH          = 8,
  parameter int DEBOUNCE_LIMIT = 19000
) (
  input  logic         CLK,
  input  logic         RST,
  calc_accum_if.slave  bus
);

  localparam int            CW    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_LIMIT);

  typedef enum logic {
    ST_EMPTY,
    ST_LOADED
  } state_t;

  // Button index 0 = enter, 1 = mode.
  logic [1:0]    w_btn_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_db;
  logic [1:0]    r_db_d;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    w_press;

  assign w_btn_raw = {bus.i_btn_mode, bus.i_btn_enter};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int b = 0; b < 2; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] != r_db[b]) begin
          // The level is accepted on the edge after the count reaches LIMIT,
          // so a change must persist for LIMIT+1 consecutive samples.
          if (r_cnt[b] == LIMIT) begin
            r_db[b]  <= r_sync2[b];
            r_cnt[b] <= '0;
          end else begin
            r_cnt[b] <= r_cnt[b] + CW'(1);
          end
        end else begin
          r_cnt[b] <= '0;
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases are ignored.
  assign w_press = r_db & ~r_db_d;

  logic r_mode_sub;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode_sub <= 1'b0;
    end else if (w_press[1]) begin
      r_mode_sub <= ~r_mode_sub;
    end
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;
  logic             r_carry;
  logic             w_carry_nxt;
  logic             r_overflow;
  logic             w_overflow_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] w_op_x;
  logic [WIDTH:0]   w_sum;

  // Subtraction is acc + ~op + 1; the carry-in is the mode bit itself. The
  // mode register is read before any same-cycle toggle lands, so a
  // simultaneous mode press only affects the following operation.
  assign w_op_x = r_mode_sub ? ~bus.i_operand : bus.i_operand;
  assign w_sum  = {1'b0, r_result} + {1'b0, w_op_x} + {{WIDTH{1'b0}}, r_mode_sub};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_EMPTY;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_result   <= w_result_nxt;
      r_carry    <= w_carry_nxt;
      r_overflow <= w_overflow_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_result_nxt   = r_result;
    w_carry_nxt    = r_carry;
    w_overflow_nxt = r_overflow;
    w_valid_nxt    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_press[0]) begin
          w_result_nxt   = bus.i_operand;
          w_carry_nxt    = 1'b0;
          w_overflow_nxt = 1'b0;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (w_press[0]) begin
          w_result_nxt   = w_sum[WIDTH-1:0];
          w_carry_nxt    = w_sum[WIDTH];
          // Same-signed inputs producing a differently signed result.
          w_overflow_nxt = (r_result[WIDTH-1] == w_op_x[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != r_result[WIDTH-1]);
          w_valid_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  assign bus.o_result   = r_result;
  assign bus.o_carry    = r_carry;
  assign bus.o_overflow = r_overflow;
  assign bus.o_mode_sub = r_mode_sub;
  assign bus.o_loaded   = (r_state == ST_LOADED);
  assign bus.o_valid    = r_valid;

endmodule

// File: tb/tb_calc_accum.sv
// tb/tb_calc_accum.sv - directed self-checking bench for calc_accum
module tb_calc_accum;

  localparam int WIDTH = 8;
  localparam int LIM   = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   valid_cnt;
  int   lat;
  int   v0;

  calc_accum_if #(.WIDTH(WIDTH)) bus ();

  calc_accum #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_LIMIT (LIM)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // o_valid is a one-cycle pulse, so each pulse is seen at exactly one negedge.
  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) valid_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Raises the selected buttons for 'hold' cycles, then idles long enough for
  // the release to debounce. lat = edges from raw rise to first o_valid.
  task automatic do_press(input logic en, input logic md, input int hold, output int lat_o);
    lat_o = 0;
    @(posedge clk); #1;
    bus.i_btn_enter = en;
    bus.i_btn_mode  = md;
    for (int i = 1; i <= hold + LIM + 8; i++) begin
      @(posedge clk); #1;
      if (i == hold) begin
        bus.i_btn_enter = 1'b0;
        bus.i_btn_mode  = 1'b0;
      end
      if (bus.o_valid === 1'b1 && lat_o == 0) lat_o = i;
    end
  endtask

  task automatic enter(input logic [7:0] op, input string tag);
    bus.i_operand = op;
    v0 = valid_cnt;
    do_press(1'b1, 1'b0, 10, lat);
    check({tag, "_valid_count"}, 32'(valid_cnt - v0), 32'd1);
  endtask

  task automatic mode_press();
    v0 = valid_cnt;
    do_press(1'b0, 1'b1, 10, lat);
    check("mode_no_valid", 32'(valid_cnt - v0), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    valid_cnt = 0;
    rst = 1'b1;
    bus.i_operand   = '0;
    bus.i_btn_enter = 1'b0;
    bus.i_btn_mode  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 32'(bus.o_result), 32'h00);
    check("rst_carry", 32'(bus.o_carry), 32'd0);
    check("rst_overflow", 32'(bus.o_overflow), 32'd0);
    check("rst_mode", 32'(bus.o_mode_sub), 32'd0);
    check("rst_loaded", 32'(bus.o_loaded), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("idle_result", 32'(bus.o_result), 32'h00);
    check("idle_loaded", 32'(bus.o_loaded), 32'd0);
    check("idle_valid_count", 32'(valid_cnt), 32'd0);

    // Build 0x37 / sub / LOADED, then reset asynchronously mid-cycle.
    enter(8'h37, "load37");
    mode_press();
    check("pre_rst_result", 32'(bus.o_result), 32'h37);
    check("pre_rst_mode", 32'(bus.o_mode_sub), 32'd1);
    check("pre_rst_loaded", 32'(bus.o_loaded), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_result", 32'(bus.o_result), 32'h00);
    check("async_rst_mode", 32'(bus.o_mode_sub), 32'd0);
    check("async_rst_loaded", 32'(bus.o_loaded), 32'd0);
    check("async_rst_flags", 32'({bus.o_carry, bus.o_overflow, bus.o_valid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load 0x05, add 0x03, with raw-rise to o_valid latency.
    enter(8'h05, "load05");
    check("load05_latency", 32'(lat), 32'(LIM + 4));
    check("load05_result", 32'(bus.o_result), 32'h05);
    check("load05_loaded", 32'(bus.o_loaded), 32'd1);
    enter(8'h03, "add03");
    check("add03_latency", 32'(lat), 32'(LIM + 4));
    check("add03_result", 32'(bus.o_result), 32'h08);
    check("add03_cv", 32'({bus.o_carry, bus.o_overflow}), 32'b00);

    // Subtract mode.
    mode_press();
    check("sub_mode", 32'(bus.o_mode_sub), 32'd1);
    enter(8'h0A, "sub0a");
    check("sub0a_result", 32'(bus.o_result), 32'hFE);
    check("sub0a_cv", 32'({bus.o_carry, bus.o_overflow}), 32'b00);
    enter(8'hFE, "subfe");
    check("subfe_result", 32'(bus.o_result), 32'h00);
    check("subfe_cv", 32'({bus.o_carry, bus.o_overflow}), 32'b10);
    enter(8'h80, "sub80");
    check("sub80_result", 32'(bus.o_result), 32'h80);
    check("sub80_cv", 32'({bus.o_carry, bus.o_overflow}), 32'b01);

    // Fresh start in add mode: signed overflow and wrap.
    pulse_reset();
    check("rst2_loaded", 32'(bus.o_loaded), 32'd0);
    enter(8'h7F, "load7f");
    check("load7f_cv", 32'({bus.o_carry, bus.o_overflow}), 32'b00);
    enter(8'h01, "add01");
    check("add01_result", 32'(bus.o_result), 32'h80);
    check("add01_cv", 32'({bus.o_carry, bus.o_overflow}), 32'b01);
    enter(8'h80, "add80");
    check("add80_result", 32'(bus.o_result), 32'h00);
    check("add80_cv", 32'({bus.o_carry, bus.o_overflow}), 32'b11);

    // Bounce: 2 high / 2 low for 20 cycles, then idle.
    bus.i_operand = 8'h10;
    v0 = valid_cnt;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      bus.i_btn_enter = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.i_btn_enter = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    repeat (LIM + 10) @(posedge clk);
    #1;
    check("bounce_valid_count", 32'(valid_cnt - v0), 32'd0);
    check("bounce_result", 32'(bus.o_result), 32'h00);

    v0 = valid_cnt;
    do_press(1'b1, 1'b0, 3, lat);
    check("pulse3_valid_count", 32'(valid_cnt - v0), 32'd0);
    check("pulse3_result", 32'(bus.o_result), 32'h00);

    v0 = valid_cnt;
    do_press(1'b1, 1'b0, 6, lat);
    check("pulse6_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("pulse6_result", 32'(bus.o_result), 32'h10);

    // Simultaneous mode+enter: add applied, then mode flips.
    bus.i_operand = 8'h01;
    v0 = valid_cnt;
    do_press(1'b1, 1'b1, 10, lat);
    check("both_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("both_result", 32'(bus.o_result), 32'h11);
    check("both_mode", 32'(bus.o_mode_sub), 32'd1);
    enter(8'h01, "after_both");
    check("after_both_result", 32'(bus.o_result), 32'h10);
    check("after_both_cv", 32'({bus.o_carry, bus.o_overflow}), 32'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
